multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: the maximum number of cycles to wait for mem_ready before it aborts the access.
REQ-002 The block SHALL have parameter CNT_W, default 32: the width of the retired-instruction counter.
REQ-003 The block SHALL have these ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  instruction bits [6:0], sampled from the instruction register in DECODE and later states.
- stall  in  1  freezes the FSM while high.
- mem_ready  in  1  memory access-complete strobe.
- mem_req  out  1  memory access request.
- mem_we  out  1  store enable.
- iord  out  1  address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  instruction register load.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update when the branch condition holds.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  ALU operation class.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source: 1 = memory data.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- bus_err  out  1  one-cycle pulse on a memory timeout.
- instret  out  CNT_W  count of retired instructions.
- busy  out  1  high in every state except FETCH.

Function
REQ-004 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM and WB.
REQ-005 Supported opcodes SHALL be:
- R 0110011
- LOAD 0000011
- OPIMM 0010011
- STORE 0100011
- BRANCH 1100011
- JALR 1100111
REQ-006 FETCH: mem_req=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00 (PC+4), then go to DECODE. Otherwise stay in FETCH.
REQ-007 DECODE SHALL last one cycle and compute branch/jump targets (alu_src_a=0, alu_src_b=10, alu_op=00).
REQ-008 An unsupported opcode in DECODE SHALL pulse illegal=1 and return to FETCH with no write enable asserted; instret SHALL NOT increment.
REQ-009 A supported opcode in DECODE SHALL go to EXEC.
REQ-010 EXEC outputs and next state per opcode:
- R: alu_src_a=1, alu_src_b=00, alu_op=10; go to WB.
- OPIMM: alu_src_a=1, alu_src_b=10, alu_op=11; go to WB.
- LOAD, STORE: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1; go to FETCH and retire.
- JALR: alu_src_a=1, alu_src_b=10, alu_op=00, pc_write=1; go to WB.
REQ-011 MEM: mem_req=1, iord=1, mem_we=1 for STORE only. On mem_ready, STORE goes to FETCH and retires; LOAD goes to WB.
REQ-012 WB SHALL assert reg_write=1 for exactly one cycle, with mem_to_reg=1 for LOAD only, then go to FETCH and retire. JALR SHALL write the link value PC+4.
REQ-013 Retiring SHALL increment instret by 1, wrapping modulo 2^CNT_W.
REQ-014 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 and mem_ready=0.
REQ-015 When the wait counter reaches TIMEOUT-1 without mem_ready, the block SHALL pulse bus_err, drop mem_req, assert no write enable and go to FETCH. A mem_ready in that same cycle SHALL win over the timeout.
REQ-016 stall=1 SHALL hold the state, the wait counter and instret, and force every write enable (ir_write, pc_write, pc_write_cond, reg_write, mem_we) to 0. mem_req SHALL hold its level. A mem_ready that arrives during a stall SHALL be ignored.
REQ-017 All outputs not listed for a state SHALL be 0.
REQ-018 Outputs SHALL be Moore outputs decoded from the registered state and opcode. The only exception is the mem_ready-qualified enables: ir_write, pc_write in FETCH, and the MEM exits.

Reset
REQ-019 rst_n=0 SHALL, asynchronously, set the state to FETCH, clear the wait counter and instret, and force every write enable and pulse output to 0.
REQ-020 A reset in the middle of an access SHALL abandon it. The first request after reset is released SHALL be a FETCH at the next rising edge.

Structure
REQ-021 A shared package SHALL hold the state enum, the opcode constants, and the alu_op and alu_src_b encodings.
REQ-022 The wait/timeout counter SHALL be one sub-module, mem_wait_timer.

Verification
REQ-023 R-type, mem_ready=1 on the first request cycle: 4 cycles FETCH→DECODE→EXEC→WB, reg_write for one cycle, instret 0→1.
REQ-024 LOAD with mem_ready delayed 3 cycles in MEM: WB follows with mem_to_reg=1, total 8 cycles.
REQ-025 STORE: mem_we=1 only in MEM, no reg_write, instret increments.
REQ-026 opcode 1111111: illegal pulses in DECODE, no write enables, instret unchanged, next state FETCH.
REQ-027 TIMEOUT=4 with mem_ready held 0: bus_err pulses on the 4th request cycle, then the FSM returns to FETCH.
REQ-028 stall=1 for 5 cycles in EXEC, then rst_n=0 pulsed inside MEM: the state is held with no write enables during the stall, and after reset the state is FETCH with instret=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Contents: the FSM state enum, the opcode constants (RV32 major opcodes),
// the ALU operation-class and ALU B-source encodings, and an opcode legality helper.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU operation class
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_IMM    = 2'b11;

  // ALU B-operand source
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_OPIMM, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// master: the controller (reads opcode/stall/mem_ready, drives all controls).
// slave : the datapath/memory side (the mirror image).
// instret width follows CNT_W.
interface multicycle_controller_if #(parameter int CNT_W = 32) ();
  logic [6:0]       opcode;
  logic             stall;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;
  logic             busy;

  modport master (
    input  opcode, stall, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           illegal, bus_err, instret, busy
  );

  modport slave (
    output opcode, stall, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
           illegal, bus_err, instret, busy
  );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on a memory access.
// Ports: clk, rst_n (async, active-low), i_clr (restart at 0, wins over i_inc),
//        i_inc (one more waiting cycle), o_expired (count has reached TIMEOUT-1).
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  // The controller clears the count on the timeout cycle itself, so the
  // counter never has to go past TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM of a multicycle RV32-subset core
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB]).
// Ports: clk, rst_n (async, active-low), bus (multicycle_controller_if.master):
//   in : opcode, stall, mem_ready
//   out: mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, alu_src_a,
//        alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err, instret, busy
// Outputs are decoded from the registered state and opcode; only ir_write/pc_write
// in FETCH and the MEM exits look at mem_ready. stall freezes everything and
// masks all write enables.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_instret;

  logic       w_run, w_access, w_expired, w_timeout, w_retire, w_clr, w_inc;
  logic       w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write, w_pc_write_cond;
  logic       w_alu_src_a, w_reg_write, w_mem_to_reg, w_illegal;
  logic [1:0] w_alu_src_b, w_alu_op;
  logic [6:0] w_op;

  assign w_op     = bus.opcode;
  // w_run: the FSM may act this cycle (not stalled, not in reset).
  assign w_run    = rst_n && !bus.stall;
  assign w_access = (r_state == S_FETCH) || (r_state == S_MEM);
  // mem_ready arriving on the expiry cycle beats the timeout.
  assign w_timeout = w_access && w_expired && !bus.mem_ready && w_run;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_state <= S_FETCH;
    else if (!bus.stall) r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: w_next = op_supported(w_op) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        case (w_op)
          OP_R, OP_OPIMM, OP_JALR: w_next = S_WB;
          OP_LOAD, OP_STORE:       w_next = S_MEM;
          default:                 w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)  w_next = (w_op == OP_STORE) ? S_FETCH : S_WB;
        else if (w_timeout) w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Output decode (before stall/reset/timeout masking)
  always_comb begin
    w_mem_req       = 1'b0;
    w_mem_we        = 1'b0;
    w_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = SRCB_RS2;
    w_alu_op        = ALU_ADD;
    w_reg_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM;
        w_illegal   = !op_supported(w_op);
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        case (w_op)
          OP_R: begin
            w_alu_src_b = SRCB_RS2;
            w_alu_op    = ALU_RTYPE;
          end
          OP_OPIMM: begin
            w_alu_src_b = SRCB_IMM;
            w_alu_op    = ALU_IMM;
          end
          OP_BRANCH: begin
            w_alu_src_b     = SRCB_RS2;
            w_alu_op        = ALU_BRANCH;
            w_pc_write_cond = 1'b1;
          end
          OP_JALR: begin
            w_alu_src_b = SRCB_IMM;
            w_pc_write  = 1'b1;
          end
          default: w_alu_src_b = SRCB_IMM;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (w_op == OP_STORE);
      end
      S_WB: begin
        // The JALR link value (PC+4 from fetch) is held by the datapath;
        // WB only strobes the register-file write.
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_op == OP_LOAD);
      end
      default: ;
    endcase
  end

  // Masking: stall and reset kill every write enable and pulse; a timeout
  // withdraws the request and any pending store.
  assign bus.mem_req       = rst_n && w_mem_req && !w_timeout;
  assign bus.mem_we        = w_run && w_mem_we && !w_timeout;
  assign bus.iord          = w_iord;
  assign bus.ir_write      = w_run && w_ir_write;
  assign bus.pc_write      = w_run && w_pc_write;
  assign bus.pc_write_cond = w_run && w_pc_write_cond;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.reg_write     = w_run && w_reg_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.illegal       = w_run && w_illegal;
  assign bus.bus_err       = w_timeout;
  assign bus.busy          = (r_state != S_FETCH);
  assign bus.instret       = r_instret;

  assign w_retire = w_run && (((r_state == S_EXEC) && (w_op == OP_BRANCH)) ||
                              ((r_state == S_MEM) && (w_op == OP_STORE) && bus.mem_ready) ||
                              (r_state == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 1'b1;
  end

  // Restart the wait count whenever FETCH or MEM is (re)entered.
  assign w_clr = w_run && (w_timeout ||
                 ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM))));
  assign w_inc = w_run && w_mem_req && !bus.mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

endmodule
